move_scheduler: RTL and testbench

MOVE_SCHEDULER -- requirements
Module: move_scheduler

---
 rtl/move_scheduler.sv | 152 +++++++++++++++
 tb/tb_move_scheduler.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/move_scheduler.sv
// Move-tick generator and turn scheduler for the snake game.
// Define TURN_QUEUE_EN for a 2-entry turn FIFO; otherwise a single latest-wins pending turn.
module move_scheduler #(
  parameter int TICK_SLOW = 20000000,
  parameter int TICK_FAST = 10000000
) (
  input  logic       clock,
  input  logic       restart_n,
  input  logic       enable,
  input  logic       pause,
  input  logic       velocity,
  input  logic [3:0] buttons,
  output logic       move_tick,
  output logic [1:0] direction,
  output logic [1:0] queue_count,
  output logic [1:0] db_state
);

  localparam int TICK_MAX = (TICK_SLOW > TICK_FAST) ? TICK_SLOW : TICK_FAST;
  localparam int CNT_W    = $clog2(TICK_MAX + 1);
  localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(TICK_SLOW - 1);
  localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(TICK_FAST - 1);

`ifdef TURN_QUEUE_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSED = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_last;
  logic             vel_q;
  logic [3:0]       btn_q;
  logic [3:0]       rise;
  logic [1:0]       dir_q, dir_d;
  logic [1:0]       fill_q, fill_d, fill_pp;
  logic [1:0]       q_q [DEPTH];
  logic [1:0]       q_d [DEPTH];
  logic [1:0]       req, hdg;
  logic             pop, push;

  // Highest-priority newly pressed button: up > down > left > right.
  function automatic logic [1:0] prio_dir(input logic [3:0] r);
    logic [1:0] d;
    if (r[3])      d = 2'b11;
    else if (r[2]) d = 2'b10;
    else if (r[1]) d = 2'b01;
    else           d = 2'b00;
    return d;
  endfunction

  // Opposite headings differ only in bit 0 (right/left, down/up).
  function automatic logic is_reject(input logic [1:0] r, input logic [1:0] h);
    return (r == h) || (r == {h[1], ~h[0]});
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    fill_d      = fill_q;
    fill_pp     = fill_q;
    q_d         = q_q;
    move_tick   = 1'b0;
    pop         = 1'b0;
    push        = 1'b0;
    hdg         = dir_q;
    period_last = vel_q ? FAST_LAST : SLOW_LAST;
    rise        = buttons & ~btn_q;
    req         = prio_dir(rise);

    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        fill_d = '0;
      end
      RUN: begin
        move_tick = (cnt_q >= period_last);
        cnt_d     = move_tick ? '0 : cnt_q + 1'b1;
        pop       = move_tick && (fill_q != 2'd0);
        if (pop) begin
          dir_d   = q_q[0];
          q_d[0]  = q_q[DEPTH-1];
          fill_pp = fill_q - 2'd1;
        end
`ifdef TURN_QUEUE_EN
        // Reference heading is the post-pop tail, or the post-pop direction when empty.
        hdg  = (fill_pp != 2'd0) ? (fill_q[1] ? q_q[1] : q_q[0]) : dir_d;
        push = (rise != 4'b0000) && !is_reject(req, hdg) && (fill_pp != 2'd2);
        if (push) begin
          q_d[fill_pp[0]] = req;
          fill_d          = fill_pp + 2'd1;
        end else begin
          fill_d = fill_pp;
        end
`else
        hdg  = dir_d;
        push = (rise != 4'b0000) && !is_reject(req, hdg);
        if (push) begin
          q_d[0] = req;
          fill_d = 2'd1;
        end else begin
          fill_d = fill_pp;
        end
`endif
      end
      PAUSED: begin
      end
      default: begin
      end
    endcase

    if (!enable)    state_d = IDLE;
    else if (pause) state_d = PAUSED;
    else            state_d = RUN;
  end

  always_ff @(posedge clock) begin
    if (!restart_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dir_q   <= 2'b00;
      fill_q  <= '0;
      btn_q   <= 4'b0000;
      vel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      fill_q  <= fill_d;
      btn_q   <= buttons;
      vel_q   <= velocity;
    end
  end

  // Queue payload needs no reset: entries beyond fill_q are never read.
  always_ff @(posedge clock) begin
    q_q <= q_d;
  end

  assign direction   = dir_q;
  assign queue_count = fill_q;
  assign db_state    = state_q;

endmodule

// File: tb/tb_move_scheduler.sv
// Self-checking bench for move_scheduler: directed scenarios plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_move_scheduler;

  localparam int TS = 8;
  localparam int TF = 4;
`ifdef TURN_QUEUE_EN
  localparam int QM = 1;
`else
  localparam int QM = 0;
`endif

  logic       clock = 1'b0;
  logic       restart_n = 1'b0;
  logic       enable = 1'b0;
  logic       pause = 1'b0;
  logic       velocity = 1'b0;
  logic [3:0] buttons = 4'b0000;
  logic       move_tick;
  logic [1:0] direction;
  logic [1:0] queue_count;
  logic [1:0] db_state;

  move_scheduler #(.TICK_SLOW(TS), .TICK_FAST(TF)) dut (
    .clock       (clock),
    .restart_n   (restart_n),
    .enable      (enable),
    .pause       (pause),
    .velocity    (velocity),
    .buttons     (buttons),
    .move_tick   (move_tick),
    .direction   (direction),
    .queue_count (queue_count),
    .db_state    (db_state)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: state 0 idle, 1 run, 2 paused; turns kept in a plain queue.
  int m_state = 0;
  int m_cnt   = 0;
  int m_dir   = 0;
  int m_prev  = 0;
  int m_vel   = 0;
  int mq[$];
  bit model_on = 0;
  int m_rise, m_req, m_hdg;
  bit m_t;

  function automatic bit m_tick();
    int per;
    per = (m_vel != 0) ? TF : TS;
    return (m_state == 1) && (m_cnt >= per - 1);
  endfunction

  always @(posedge clock) begin
    if (!restart_n) begin
      m_state = 0; m_cnt = 0; m_dir = 0; m_prev = 0; m_vel = 0;
      mq.delete();
      model_on = 1;
    end else begin
      m_t    = m_tick();
      m_rise = int'(buttons) & ~m_prev;
      m_prev = int'(buttons);
      if (m_state == 0) begin
        m_cnt = 0;
        mq.delete();
      end else if (m_state == 1) begin
        m_cnt = m_t ? 0 : m_cnt + 1;
        if (m_t && mq.size() > 0) m_dir = mq.pop_front();
        if (m_rise != 0) begin
          m_req = m_rise[3] ? 3 : m_rise[2] ? 2 : m_rise[1] ? 1 : 0;
`ifdef TURN_QUEUE_EN
          m_hdg = (mq.size() > 0) ? mq[$] : m_dir;
          if (m_req != m_hdg && m_req != (m_hdg ^ 1) && mq.size() < 2) mq.push_back(m_req);
`else
          m_hdg = m_dir;
          if (m_req != m_hdg && m_req != (m_hdg ^ 1)) begin
            mq.delete();
            mq.push_back(m_req);
          end
`endif
        end
      end
      m_state = !enable ? 0 : (pause ? 2 : 1);
      m_vel   = velocity ? 1 : 0;
    end
  end

  always @(negedge clock) begin
    if (model_on) begin
      check("move_tick", int'(move_tick), int'(m_tick()));
      check("direction", int'(direction), m_dir);
      check("queue_count", int'(queue_count), mq.size());
      check("db_state", int'(db_state), m_state);
    end
  end

  task automatic cycle();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    while (!move_tick && n < 50) begin
      cycle();
      n++;
    end
  endtask

  task automatic press(input logic [3:0] b);
    buttons = b;
    cycle();
    buttons = 4'b0000;
    cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bit saw;
    restart_n = 1'b0;
    repeat (2) cycle();
    restart_n = 1'b1;
    check("rst_direction", int'(direction), 0);
    check("rst_queue_count", int'(queue_count), 0);
    check("rst_state", int'(db_state), 0);
    check("rst_move_tick", int'(move_tick), 0);

    enable = 1'b1;
    cycle();
    check("enter_run", int'(db_state), 1);
    wait_tick(n);
    check("first_tick_latency", n + 1, 8);
    cycle();
    wait_tick(n);
    check("slow_period", n + 1, 8);

    buttons = 4'b1000;
    cycle();
    check("up_queued", int'(queue_count), 1);
    wait_tick(n);
    check("dir_before_pop", int'(direction), 0);
    cycle();
    check("dir_after_pop", int'(direction), 3);
    check("queue_after_pop", int'(queue_count), 0);
    repeat (2) cycle();
    check("held_single_request", int'(queue_count), 0);
    buttons = 4'b0000;

    wait_tick(n);
    cycle();
    press(4'b0100);
    check("reverse_dropped", int'(queue_count), 0);

    wait_tick(n);
    cycle();
    press(4'b0010);
    press(4'b0100);
    press(4'b0001);
    check("queue_full", int'(queue_count), QM ? 2 : 1);

    pause = 1'b1;
    cycle();
    check("paused_state", int'(db_state), 2);
    saw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (move_tick) saw = 1'b1;
      buttons = (i == 5) ? 4'b0010 : 4'b0000;
      cycle();
    end
    buttons = 4'b0000;
    check("no_tick_paused", int'(saw), 0);
    check("count_frozen", int'(queue_count), QM ? 2 : 1);
    pause = 1'b0;
    wait_tick(n);
    check("resume_remaining", n, 1);
    cycle();
    check("dir_first_pop", int'(direction), QM ? 1 : 0);
    wait_tick(n);
    cycle();
    check("dir_second_pop", int'(direction), QM ? 2 : 0);
    check("queue_drained", int'(queue_count), 0);

    cycle();
    buttons = QM ? 4'b0111 : 4'b1101;
    cycle();
    buttons = 4'b0000;
    check("priority_select", int'(queue_count), QM ? 0 : 1);

    wait_tick(n);
    cycle();
    repeat (5) cycle();
    velocity = 1'b1;
    cycle();
    check("velocity_switch_tick", int'(move_tick), 1);
    cycle();
    wait_tick(n);
    check("fast_period", n + 1, 4);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      if ($urandom_range(0, 24) == 0) pause = ~pause;
      if ($urandom_range(0, 49) == 0) velocity = ~velocity;
      buttons   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      restart_n = ($urandom_range(0, 299) != 0);
      cycle();
    end

    restart_n = 1'b1;
    enable    = 1'b1;
    pause     = 1'b0;
    velocity  = 1'b0;
    buttons   = 4'b0000;
    repeat (4) cycle();
    buttons = 4'b1000;
    cycle();
    buttons   = 4'b0000;
    restart_n = 1'b0;
    cycle();
    restart_n = 1'b1;
    check("midrun_rst_state", int'(db_state), 0);
    check("midrun_rst_direction", int'(direction), 0);
    check("midrun_rst_queue", int'(queue_count), 0);
    check("midrun_rst_tick", int'(move_tick), 0);
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
